// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles under a
// three-state controller (IDLE -> SHIFT -> DONE -> IDLE).

module fullAdder (
    input  logic inA,
    input  logic inB,
    input  logic carryIn,
    output logic sum,
    output logic carryOut
);
    assign sum      = inA ^ inB ^ carryIn;
    assign carryOut = (inA & inB) | (carryIn & (inA ^ inB));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_nxt;

    fullAdder u_fa (
        .inA      (a_sh[0]),
        .inB      (b_sh[0]),
        .carryIn  (cy),
        .sum      (fa_sum),
        .carryOut (fa_cout)
    );

    // Result builds from the top; the oldest bit falls off once complete.
    assign res_nxt = {fa_sum, res_sh};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryOut <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= opA;
                        b_sh  <= opB;
                        cy    <= carryIn;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt[WIDTH-1:1];
                    cy     <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum      <= res_nxt;
                        carryOut <= fa_cout;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
